// File: rtl/fetch_ctrl_pkg.sv
// Shared fetch-control types: PC source select, controller state, redirect ranking.
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif

package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    pc_plus_4_t = 2'd0,
    sb_t        = 2'd1,
    uj_t        = 2'd2,
    jalr_t      = 2'd3
  } next_pc_t;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    REDIR,
    BUBBLE,
    DRAIN,
    DONE
  } fetch_state_t;

  // Higher value wins: jalr > sb > uj.
  function automatic logic [1:0] redirect_rank(input next_pc_t t);
    case (t)
      jalr_t:  return 2'd3;
      sb_t:    return 2'd2;
      uj_t:    return 2'd1;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/fetch_ctrl_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_cnt
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch redirect controller: arbitrates branch/jump redirects, inserts bubbles,
// and tracks end-of-program drain to a halted state.
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif

module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned INST_ADDR_WIDTH = `INST_ADDR_WIDTH,
  parameter int unsigned BUBBLE_CYCLES   = 1,
  parameter int unsigned CNT_WIDTH       = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       sb_req_i,
  input  logic                       uj_req_i,
  input  logic                       jalr_req_i,
  input  logic [INST_ADDR_WIDTH-1:0] sb_addr_i,
  input  logic [INST_ADDR_WIDTH-1:0] uj_addr_i,
  input  logic [INST_ADDR_WIDTH-1:0] jalr_addr_i,
  input  logic                       backend_stall_i,
  input  logic                       seen_last_inst,
  input  logic                       backend_empty_i,
  output next_pc_t                   next_pc_sel,
  output logic [INST_ADDR_WIDTH-1:0] SB_Type_addr,
  output logic [INST_ADDR_WIDTH-1:0] UJ_Type_addr,
  output logic [INST_ADDR_WIDTH-1:0] JALR_Type_addr,
  output logic                       stall,
  output logic                       halted_o,
  output logic [CNT_WIDTH-1:0]       redirect_cnt_o
);

  localparam logic [2:0] BUB_LOAD = (BUBBLE_CYCLES == 0) ? 3'd0 : 3'(BUBBLE_CYCLES - 1);

  fetch_state_t               r_state;
  next_pc_t                   r_pend_type;
  logic [INST_ADDR_WIDTH-1:0] r_pend_addr;
  logic [INST_ADDR_WIDTH-1:0] r_sb_addr;
  logic [INST_ADDR_WIDTH-1:0] r_uj_addr;
  logic [INST_ADDR_WIDTH-1:0] r_jalr_addr;
  logic [2:0]                 r_bub_cnt;

  next_pc_t                   w_req_type;
  logic [INST_ADDR_WIDTH-1:0] w_req_addr;
  logic                       w_req_any;
  logic                       w_accept;

  always_comb begin
    w_req_type = pc_plus_4_t;
    w_req_addr = '0;
    if (jalr_req_i) begin
      w_req_type = jalr_t;
      w_req_addr = jalr_addr_i;
    end else if (sb_req_i) begin
      w_req_type = sb_t;
      w_req_addr = sb_addr_i;
    end else if (uj_req_i) begin
      w_req_type = uj_t;
      w_req_addr = uj_addr_i;
    end
  end

  assign w_req_any = jalr_req_i | sb_req_i | uj_req_i;

  // While a redirect is stalled in REDIR only an equal-or-higher priority request may replace it.
  always_comb begin
    w_accept = 1'b0;
    case (r_state)
      RUN, BUBBLE, DRAIN: w_accept = w_req_any;
      REDIR:              w_accept = w_req_any && backend_stall_i &&
                                     (redirect_rank(w_req_type) >= redirect_rank(r_pend_type));
      default:            w_accept = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_pend_type <= pc_plus_4_t;
      r_pend_addr <= '0;
      r_sb_addr   <= '0;
      r_uj_addr   <= '0;
      r_jalr_addr <= '0;
      r_bub_cnt   <= '0;
    end else begin
      if (w_accept) begin
        r_pend_type <= w_req_type;
        r_pend_addr <= w_req_addr;
        case (w_req_type)
          sb_t:    r_sb_addr   <= w_req_addr;
          uj_t:    r_uj_addr   <= w_req_addr;
          jalr_t:  r_jalr_addr <= w_req_addr;
          default: ;
        endcase
      end

      case (r_state)
        IDLE: r_state <= RUN;
        RUN: begin
          if (w_accept)            r_state <= REDIR;
          else if (seen_last_inst) r_state <= DRAIN;
        end
        REDIR: begin
          if (!backend_stall_i) begin
            if (BUBBLE_CYCLES == 0) begin
              r_state <= RUN;
            end else begin
              r_state   <= BUBBLE;
              r_bub_cnt <= BUB_LOAD;
            end
          end
        end
        BUBBLE: begin
          if (w_accept)            r_state   <= REDIR;
          else if (r_bub_cnt == 0) r_state   <= RUN;
          else                     r_bub_cnt <= r_bub_cnt - 3'd1;
        end
        DRAIN: begin
          if (w_accept)             r_state <= REDIR;
          else if (backend_empty_i) r_state <= DONE;
        end
        DONE:    r_state <= DONE;
        default: r_state <= IDLE;
      endcase
    end
  end

  sat_counter #(
    .WIDTH(CNT_WIDTH)
  ) u_redirect_cnt (
    .i_clk (clk),
    .i_rst (reset),
    .i_inc (w_accept),
    .o_cnt (redirect_cnt_o)
  );

  assign next_pc_sel    = (r_state == REDIR) ? r_pend_type : pc_plus_4_t;
  assign SB_Type_addr   = r_sb_addr;
  assign UJ_Type_addr   = r_uj_addr;
  assign JALR_Type_addr = r_jalr_addr;
  assign stall          = ((r_state == RUN) || (r_state == REDIR)) ? backend_stall_i : 1'b1;
  assign halted_o       = (r_state == DONE);

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter INST_ADDR_WIDTH, default `INST_ADDR_WIDTH: instruction address width.
REQ-002 SHALL have parameter BUBBLE_CYCLES, default 1: stall cycles inserted after each redirect (legal 0..7).
REQ-003 SHALL have parameter CNT_WIDTH, default 16: redirect counter width.
REQ-004 SHALL have port clk  input  1: single clock, rising edge.
REQ-005 SHALL have port reset  input  1: asynchronous, active-high reset.
REQ-006 SHALL have ports sb_req_i, uj_req_i, jalr_req_i  input  1 each: redirect requests (branch taken, JAL, JALR).
REQ-007 SHALL have ports sb_addr_i, uj_addr_i, jalr_addr_i  input  INST_ADDR_WIDTH each: target of the matching request.
REQ-008 SHALL have port backend_stall_i  input  1: downstream cannot accept a fetch group.
REQ-009 SHALL have port seen_last_inst  input  1: fetch unit reports end of code.
REQ-010 SHALL have port backend_empty_i  input  1: no instructions in flight downstream.
REQ-011 SHALL have port next_pc_sel  output  next_pc_t: PC source to fetch unit.
REQ-012 SHALL have ports SB_Type_addr, UJ_Type_addr, JALR_Type_addr  output  INST_ADDR_WIDTH each: registered targets to fetch unit.
REQ-013 SHALL have port stall  output  1: fetch unit stall.
REQ-014 SHALL have port halted_o  output  1: program finished.
REQ-015 SHALL have port redirect_cnt_o  output  CNT_WIDTH: accepted-redirect count.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, REDIR, BUBBLE, DRAIN, DONE.
REQ-017 SHALL, when several requests are high in one cycle, select by priority jalr > sb > uj; lower ones dropped.
REQ-018 SHALL latch the selected type and address into a pending register at the accepting edge; outputs reflect it next cycle (1-cycle latency).
REQ-019 SHALL, in REDIR, drive next_pc_sel = pending type and the matching *_Type_addr = pending address; the other addresses hold their last values.
REQ-020 SHALL drive next_pc_sel = pc_plus_4_t in every state except REDIR.
REQ-021 SHALL drive stall = backend_stall_i in RUN and REDIR, and 1 in IDLE, BUBBLE, DRAIN, DONE.
REQ-022 SHALL treat the redirect as consumed at an edge in REDIR where stall = 0; then go to BUBBLE (load counter BUBBLE_CYCLES-1) or, if BUBBLE_CYCLES = 0, to RUN.
REQ-023 SHALL, while REDIR and stall = 1, hold the pending redirect; a new request overwrites it only if of equal or higher priority.
REQ-024 SHALL decrement the bubble counter each cycle in BUBBLE and go to RUN when it reaches 0.
REQ-025 SHALL go IDLE -> RUN unconditionally after one cycle.
REQ-026 SHALL accept a request in RUN, BUBBLE or DRAIN and go to REDIR (BUBBLE counter discarded).
REQ-027 SHALL go RUN -> DRAIN when seen_last_inst = 1 and no request; request wins if simultaneous.
REQ-028 SHALL go DRAIN -> DONE when backend_empty_i = 1 and no request.
REQ-029 SHALL ignore all requests in IDLE and DONE; DONE exits only by reset.
REQ-030 SHALL assert halted_o only in DONE.
REQ-031 SHALL increment redirect_cnt_o by 1 per accepted request (including overwrites), saturating at all-ones.

Reset
REQ-032 SHALL on reset enter IDLE; next_pc_sel = pc_plus_4_t, all addresses 0, stall = 1, halted_o = 0, redirect_cnt_o = 0, pending cleared.
REQ-033 SHALL on reset mid-redirect discard the pending redirect.

Structure
REQ-034 SHALL take next_pc_t from the shared package and add the FSM state enum there.
REQ-035 SHALL be a single module; a saturating-counter sub-module sat_counter is permitted.

Verification
REQ-036 SHALL cover: sb_req_i=1, sb_addr_i=0x40, no stall -> next cycle next_pc_sel=sb, SB_Type_addr=0x40; next cycle stall=1 for 1 cycle; redirect_cnt_o=1.
REQ-037 SHALL cover: jalr_req_i and sb_req_i together (0x80/0x40) -> JALR_Type_addr=0x80, next_pc_sel=jalr, sb dropped, cnt=1.
REQ-038 SHALL cover: uj redirect 0x20 with backend_stall_i=1 for 3 cycles, then sb 0x60 arrives -> REDIR holds, overwritten to sb/0x60, consumed on first stall-free edge, cnt=2.
REQ-039 SHALL cover: seen_last_inst=1 in RUN, backend_empty_i=1 after 4 cycles -> stall=1 throughout, halted_o=1 one cycle after empty; later requests ignored.
REQ-040 SHALL cover: seen_last_inst and uj_req_i together -> REDIR, not DRAIN.
REQ-041 SHALL cover: reset asserted in REDIR -> outputs at reset values immediately, IDLE then RUN, pending lost.
